// File: rtl/m68k_bus_arbiter_if.sv
// m68k_bus_arbiter_if: handshake and status signals between the 68K bus
// arbiter, the board-side BR/BG/BGACK pins and the bus-cycle engine.
// The arbiter connects through the slave modport; the environment that
// drives requests and observes grants uses the master modport.
interface m68k_bus_arbiter_if;
    logic       M68K_BR_n;
    logic       M68K_BGACK_n;
    logic       op_req;
    logic       cyc_active;
    logic       cyc_end;
    logic       cyc_start_ok;
    logic       M68K_BG_n;
    logic       bus_released;
    logic [2:0] arb_state;
    logic       wd_error;

    modport slave (
        input  M68K_BR_n,
        input  M68K_BGACK_n,
        input  op_req,
        input  cyc_active,
        input  cyc_end,
        output cyc_start_ok,
        output M68K_BG_n,
        output bus_released,
        output arb_state,
        output wd_error
    );

    modport master (
        output M68K_BR_n,
        output M68K_BGACK_n,
        output op_req,
        output cyc_active,
        output cyc_end,
        input  cyc_start_ok,
        input  M68K_BG_n,
        input  bus_released,
        input  arb_state,
        input  wd_error
    );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter: clocked owner FSM for the Amiga 68K bus, shared between
// the cycle engine and BR/BG/BGACK DMA masters. BG_n is only asserted at
// cycle boundaries and bus_released tells the pads to tri-state.
// Optional feature: define ARB_BG_WATCHDOG_EN to add a BG-without-BGACK
// watchdog (GRANT times out after BG_TIMEOUT clocks, sticky wd_error).
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int REARB_CLKS  = 2,
    parameter int BG_TIMEOUT  = 64
) (
    input logic               M68K_CLK,
    input logic               RESET,
    m68k_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        PI_OWN  = 3'd0,
        DRAIN   = 3'd1,
        GRANT   = 3'd2,
        EXT_OWN = 3'd3,
        REARB   = 3'd4
    } state_t;

    localparam logic [2:0] REARB_LAST = 3'(REARB_CLKS - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("m68k_bus_arbiter: SYNC_STAGES must be 2 or 3");
    end
    if (REARB_CLKS < 1 || REARB_CLKS > 7) begin : g_bad_rearb
        $error("m68k_bus_arbiter: REARB_CLKS must be 1..7");
    end
    if (BG_TIMEOUT < 1 || BG_TIMEOUT > 127) begin : g_bad_timeout
        $error("m68k_bus_arbiter: BG_TIMEOUT must fit the 7-bit watchdog");
    end

    logic [SYNC_STAGES-1:0] br_sync_q;
    logic [SYNC_STAGES-1:0] bgack_sync_q;
    logic                   br;
    logic                   bgack;
    state_t                 state_q;
    state_t                 state_d;
    logic                   ready_q;
    logic                   drain_end_q;
    logic                   drain_end_d;
    logic [2:0]             rearb_cnt_q;
    logic [2:0]             rearb_cnt_d;
    logic                   wd_fire;
    logic                   bg_n;
    logic                   released;
    logic                   start_ok;

    // Synchronise the asynchronous BR/BGACK pins; preset to the inactive level
    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) begin
            br_sync_q    <= '1;
            bgack_sync_q <= '1;
        end else begin
            br_sync_q    <= {br_sync_q[SYNC_STAGES-2:0], bus.M68K_BR_n};
            bgack_sync_q <= {bgack_sync_q[SYNC_STAGES-2:0], bus.M68K_BGACK_n};
        end
    end

    assign br    = ~br_sync_q[SYNC_STAGES-1];
    assign bgack = ~bgack_sync_q[SYNC_STAGES-1];

    // State, re-arbitration counter and start-up hold-off registers
    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= PI_OWN;
            ready_q     <= 1'b0;
            drain_end_q <= 1'b0;
            rearb_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            drain_end_q <= drain_end_d;
            rearb_cnt_q <= rearb_cnt_d;
        end
    end

    // Next-state and output decode; outputs depend only on registered state
    // and synchronised pins, plus op_req for the start permission
    always_comb begin
        state_d     = state_q;
        drain_end_d = 1'b0;
        rearb_cnt_d = '0;
        bg_n        = 1'b1;
        released    = 1'b0;
        start_ok    = 1'b0;
        case (state_q)
            PI_OWN: begin
                // ready_q keeps the engine parked for the first clock after reset
                start_ok = ready_q & bus.op_req & ~br;
                if (br) begin
                    // A cycle still on the bus, or one just entering S7, must
                    // finish before BG may go low
                    if (bus.cyc_active || bus.cyc_end) begin
                        state_d     = DRAIN;
                        drain_end_d = bus.cyc_end;
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            DRAIN: begin
                // drain_end_q remembers an S7 seen on the edge we entered DRAIN
                drain_end_d = drain_end_q;
                if (!br) begin
                    state_d = PI_OWN;
                end else if (bus.cyc_end || drain_end_q) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bg_n     = 1'b0;
                released = 1'b1;
                if (bgack) begin
                    state_d = EXT_OWN;
                end else if (!br || wd_fire) begin
                    state_d = REARB;
                end
            end
            EXT_OWN: begin
                bg_n     = ~br;
                released = 1'b1;
                if (!bgack) begin
                    state_d = br ? GRANT : REARB;
                end
            end
            REARB: begin
                released = 1'b1;
                if (br) begin
                    state_d = GRANT;
                end else if (rearb_cnt_q == REARB_LAST) begin
                    state_d = PI_OWN;
                end else begin
                    rearb_cnt_d = rearb_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = PI_OWN;
            end
        endcase
    end

`ifdef ARB_BG_WATCHDOG_EN
    localparam logic [6:0] WD_LAST = 7'(BG_TIMEOUT - 1);

    logic [6:0] wd_cnt_q;
    logic [6:0] wd_cnt_d;
    logic       wd_err_q;

    assign wd_fire  = (state_q == GRANT) && br && !bgack && (wd_cnt_q == WD_LAST);
    assign wd_cnt_d = (state_q == GRANT && state_d == GRANT) ? wd_cnt_q + 7'd1 : 7'd0;

    // Count clocks spent in GRANT; the error flag stays set until reset
    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_fire) begin
                wd_err_q <= 1'b1;
            end
        end
    end

    assign bus.wd_error = wd_err_q;
`else
    assign wd_fire      = 1'b0;
    assign bus.wd_error = 1'b0;
`endif

    assign bus.cyc_start_ok = start_ok;
    assign bus.M68K_BG_n    = bg_n;
    assign bus.bus_released = released;
    assign bus.arb_state    = state_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb_m68k_bus_arbiter: directed-vector bench for m68k_bus_arbiter with
// default parameters (SYNC_STAGES=2, REARB_CLKS=2, BG_TIMEOUT=64).
module tb_m68k_bus_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   bg_low_cnt;

    m68k_bus_arbiter_if bus_if ();

    m68k_bus_arbiter dut (
        .M68K_CLK (clk),
        .RESET    (rst),
        .bus      (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Bus-safety invariants sampled on every falling edge outside reset
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("bg_during_cycle", int'(!bus_if.M68K_BG_n && bus_if.cyc_active), 0);
            check_eq("start_while_released", int'(bus_if.cyc_start_ok && bus_if.bus_released), 0);
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.M68K_BR_n    = 1'b1;
        bus_if.M68K_BGACK_n = 1'b1;
        bus_if.op_req       = 1'b1;
        bus_if.cyc_active   = 1'b0;
        bus_if.cyc_end      = 1'b0;
        #12;
        check_eq("rst_state", int'(bus_if.arb_state), 0);
        check_eq("rst_bg_n", int'(bus_if.M68K_BG_n), 1);
        check_eq("rst_released", int'(bus_if.bus_released), 0);
        check_eq("rst_start_ok", int'(bus_if.cyc_start_ok), 0);
        check_eq("rst_wd", int'(bus_if.wd_error), 0);
        rst = 1'b0;
        #1;
        check_eq("start_ok_first_clk", int'(bus_if.cyc_start_ok), 0);
        step(2);
        check_eq("start_ok_idle", int'(bus_if.cyc_start_ok), 1);
        check_eq("bg_idle", int'(bus_if.M68K_BG_n), 1);

        // br while the engine is in S3, drained by cyc_end
        bus_if.cyc_active = 1'b1;
        bus_if.M68K_BR_n  = 1'b0;
        step(1);
        check_eq("drain_wait_sync", int'(bus_if.arb_state), 0);
        step(1);
        check_eq("drain_br_wins", int'(bus_if.cyc_start_ok), 0);
        check_eq("drain_still_pi", int'(bus_if.arb_state), 0);
        step(1);
        check_eq("drain_entered", int'(bus_if.arb_state), 1);
        check_eq("drain_bg_n", int'(bus_if.M68K_BG_n), 1);
        step(1);
        check_eq("drain_hold", int'(bus_if.arb_state), 1);
        bus_if.cyc_active = 1'b0;
        step(1);
        check_eq("drain_s5", int'(bus_if.arb_state), 1);
        bus_if.cyc_end = 1'b1;
        #1;
        check_eq("drain_bg_at_end", int'(bus_if.M68K_BG_n), 1);
        step(1);
        bus_if.cyc_end = 1'b0;
        check_eq("grant_state", int'(bus_if.arb_state), 2);
        check_eq("grant_bg_n", int'(bus_if.M68K_BG_n), 0);
        check_eq("grant_released", int'(bus_if.bus_released), 1);

        // BGACK taken for 20 clocks, BR released at the same time
        bus_if.M68K_BGACK_n = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        step(2);
        check_eq("grant_until_bgack", int'(bus_if.arb_state), 2);
        step(1);
        check_eq("ext_state", int'(bus_if.arb_state), 3);
        check_eq("ext_bg_n_br_gone", int'(bus_if.M68K_BG_n), 1);
        check_eq("ext_released", int'(bus_if.bus_released), 1);
        step(17);
        check_eq("ext_hold", int'(bus_if.arb_state), 3);
        bus_if.M68K_BGACK_n = 1'b1;
        step(3);
        check_eq("rearb_state", int'(bus_if.arb_state), 4);
        check_eq("rearb_released", int'(bus_if.bus_released), 1);
        check_eq("rearb_bg_n", int'(bus_if.M68K_BG_n), 1);
        step(1);
        check_eq("rearb_2nd_clk", int'(bus_if.arb_state), 4);
        step(1);
        check_eq("pi_back", int'(bus_if.arb_state), 0);
        check_eq("pi_back_released", int'(bus_if.bus_released), 0);
        check_eq("pi_back_start_ok", int'(bus_if.cyc_start_ok), 1);
        bus_if.op_req = 1'b0;
        #1;
        check_eq("start_ok_follows_req", int'(bus_if.cyc_start_ok), 0);
        bus_if.op_req = 1'b1;

        // BR pulsed for three clocks with no BGACK: grant rescinded
        bus_if.M68K_BR_n = 1'b0;
        bg_low_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (i == 3) bus_if.M68K_BR_n = 1'b1;
            if (i == 2) bus_if.M68K_BR_n = 1'b1;
            if (!bus_if.M68K_BG_n) bg_low_cnt++;
            if (i == 5) check_eq("pulse_rescind", int'(bus_if.arb_state), 4);
        end
        check_eq("pulse_bg_low_clks", bg_low_cnt, 3);
        check_eq("pulse_back_pi", int'(bus_if.arb_state), 0);

        // br rising on the same edge as cyc_end goes through DRAIN
        bus_if.M68K_BR_n = 1'b0;
        step(2);
        bus_if.cyc_end = 1'b1;
        step(1);
        bus_if.cyc_end = 1'b0;
        check_eq("simul_drain", int'(bus_if.arb_state), 1);
        check_eq("simul_bg_n", int'(bus_if.M68K_BG_n), 1);
        step(1);
        check_eq("simul_grant", int'(bus_if.arb_state), 2);
        bus_if.M68K_BR_n = 1'b1;
        step(6);
        check_eq("simul_back_pi", int'(bus_if.arb_state), 0);

        // br withdrawn while draining returns to PI_OWN
        bus_if.cyc_active = 1'b1;
        bus_if.M68K_BR_n  = 1'b0;
        step(1);
        bus_if.M68K_BR_n = 1'b1;
        step(2);
        check_eq("drain_abort_enter", int'(bus_if.arb_state), 1);
        step(1);
        check_eq("drain_abort_pi", int'(bus_if.arb_state), 0);
        bus_if.cyc_active = 1'b0;

        // BR held with no BGACK for 64 clocks of GRANT
        bus_if.M68K_BR_n = 1'b0;
        step(3);
        check_eq("wd_grant_entry", int'(bus_if.arb_state), 2);
        step(63);
        check_eq("wd_grant_63", int'(bus_if.arb_state), 2);
        check_eq("wd_clear_63", int'(bus_if.wd_error), 0);
        step(1);
`ifdef ARB_BG_WATCHDOG_EN
        check_eq("wd_timeout_state", int'(bus_if.arb_state), 4);
        check_eq("wd_timeout_flag", int'(bus_if.wd_error), 1);
        step(1);
        check_eq("wd_regrant", int'(bus_if.arb_state), 2);
        check_eq("wd_sticky", int'(bus_if.wd_error), 1);
`else
        check_eq("nowd_grant_holds", int'(bus_if.arb_state), 2);
        check_eq("nowd_flag", int'(bus_if.wd_error), 0);
        step(1);
        check_eq("nowd_grant_holds2", int'(bus_if.arb_state), 2);
`endif
        bus_if.M68K_BR_n = 1'b1;
        step(6);
        check_eq("wd_back_pi", int'(bus_if.arb_state), 0);

        // Reset asserted mid-period while an external master owns the bus
        bus_if.M68K_BR_n    = 1'b0;
        bus_if.M68K_BGACK_n = 1'b0;
        step(4);
        check_eq("ext2_state", int'(bus_if.arb_state), 3);
        check_eq("ext2_bg_n", int'(bus_if.M68K_BG_n), 0);
        rst = 1'b1;
        #1;
        check_eq("async_rst_state", int'(bus_if.arb_state), 0);
        check_eq("async_rst_bg_n", int'(bus_if.M68K_BG_n), 1);
        check_eq("async_rst_released", int'(bus_if.bus_released), 0);
        check_eq("async_rst_wd", int'(bus_if.wd_error), 0);
        bus_if.M68K_BR_n    = 1'b1;
        bus_if.M68K_BGACK_n = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        check_eq("post_rst_start_ok", int'(bus_if.cyc_start_ok), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: run exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Synchronous arbiter for ownership of the Amiga 68K bus, shared between the PiStorm'X bus-cycle engine and external DMA masters that use the BR/BG/BGACK protocol.
- Decides when the cycle engine may start a new S2.
- Drives BG_n only at legal cycle boundaries.
- Tells the pad logic when to tri-state AS/UDS/LDS/RW/VMA/A/D.
- Replaces the asynchronous set/reset grant latch with a clocked FSM.

Parameters:
SYNC_STAGES, 2, synchroniser depth for M68K_BR_n and M68K_BGACK_n (legal values 2-3)
REARB_CLKS, 2, M68K_CLK cycles to wait after BGACK release before the Pi side may start a cycle again (1-7)
BG_TIMEOUT, 64, watchdog limit in clocks for BG asserted without a BGACK response (used only with the optional feature)

Ports:
M68K_CLK  input  1  7 MHz bus clock; all state changes on the rising edge
RESET  input  1  asynchronous, active-high
M68K_BR_n  input  1  bus request from the motherboard, asynchronous
M68K_BGACK_n  input  1  bus grant acknowledge, asynchronous
op_req  input  1  the Pi has a transaction pending
cyc_active  input  1  the cycle engine is in S2..S4 (the bus is being driven)
cyc_end  input  1  one-clock pulse when the cycle engine enters S7
cyc_start_ok  output  1  permission for the cycle engine to leave S1 into S2
M68K_BG_n  output  1  bus grant, active low
bus_released  output  1  1 = tri-state all master outputs
arb_state  output  3  current FSM state (debug/status)
wd_error  output  1  sticky watchdog flag (0 when the feature is compiled out)

Behaviour:
- Reset values, applied immediately on RESET: state = PI_OWN, M68K_BG_n = 1, bus_released = 0, cyc_start_ok = 0, wd_error = 0, synchronisers preset to 1 (inactive). cyc_start_ok must stay 0 in the first clock after RESET falls.
- Inputs: br = synchronised !M68K_BR_n; bgack = synchronised !M68K_BGACK_n. Latency from pin to state decision is SYNC_STAGES clocks.
- States (arb_state encoding):
  - PI_OWN = 0: cyc_start_ok = op_req & !br; BG_n = 1; released = 0.
    - If br & !cyc_active & !cyc_end → GRANT.
    - If br & cyc_active → DRAIN.
  - DRAIN = 1: cyc_start_ok = 0. Wait for cyc_end, then → GRANT on the next edge. If br drops before cyc_end → PI_OWN.
  - GRANT = 2: BG_n = 0; released = 1 (from this state onward the Pi master no longer drives).
    - If bgack → EXT_OWN.
    - If !br & !bgack → REARB (request withdrawn, grant rescinded).
  - EXT_OWN = 3: BG_n = 0 while br, BG_n = 1 once br drops; released = 1. When !bgack & !br → REARB. When !bgack & br (second master chained) → GRANT.
  - REARB = 4: released = 1, BG_n = 1. Count REARB_CLKS clocks. If br reasserts during the count → GRANT. Otherwise → PI_OWN at the terminal count, with released = 0 on the same edge.
- Simultaneous events:
  - cyc_end and br rising on the same edge in PI_OWN → DRAIN. This is never a direct GRANT while the engine is in S7.
  - op_req and br both active in PI_OWN → br wins: cyc_start_ok = 0.
- Never assert BG_n = 0 while cyc_active = 1. Never assert cyc_start_ok while released = 1.
- RESET in mid-grant: BG_n returns to 1 and released to 0 asynchronously. External masters are expected to be in reset as well.
- Unused state encodings 5-7 → PI_OWN.

Optional Feature:
- Macro ARB_BG_WATCHDOG_EN.
- When defined: a 7-bit counter runs in GRANT and clears on entry.
  - If it reaches BG_TIMEOUT without bgack, the FSM goes to REARB and sets wd_error = 1.
  - wd_error is sticky until RESET.
  - A still-active br after REARB re-requests normally.
- When not defined: GRANT waits indefinitely, wd_error is tied to 0, and no counter logic exists.

Test Plan:
1. Idle bus, op_req = 1, no br → cyc_start_ok = 1 from the 2nd clock after reset; BG_n stays 1 for the whole run.
2. br asserted while cyc_active = 1 (engine in S3), cyc_end 4 clocks later → BG_n stays 1 until the edge after cyc_end, then 0; arb_state sequence 0,1,2.
3. GRANT then BGACK low for 20 clocks with BR released → EXT_OWN; BG_n = 1 after br drops; BGACK high → REARB for exactly REARB_CLKS = 2 clocks → PI_OWN, released = 0, cyc_start_ok follows op_req.
4. BR pulsed low for 3 clocks with no BGACK → GRANT then REARB (grant rescinded), BG_n low for at most SYNC_STAGES + 1 clocks.
5. With ARB_BG_WATCHDOG_EN and BG_TIMEOUT = 64, BR held with no BGACK → at clock 64 of GRANT: wd_error = 1, state = REARB, then back to GRANT because br is still active.
6. Assert RESET while in EXT_OWN → same delta cycle: BG_n = 1, released = 0, arb_state = 0, wd_error = 0.
